pipe_exec_core: RTL and testbench

PIPE_EXEC_CORE -- requirements
Module: pipe_exec_core

---
 rtl/pipe_exec_core.sv | 272 +++++++++++++++++++++++++++
 tb/tb_pipe_exec_core.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_exec_core.sv
// pipe_exec_core: four-stage (ID / EX / MEM / WB) integer execution core.
// Ops are read from the register file at issue (ID), computed in EX, access
// data memory in MEM and commit to the register file in WB.
// Optional feature macro: PIPE_EXEC_FWD_EN
//   defined   -> EX operand bypass (MEM over WB over register file) plus a
//                one-cycle load-use stall
//   undefined -> no bypass; a dependent op waits until its producer is in WB
//                and picks the value up through the write-first register file
module pipe_exec_core #(
  parameter  int DW   = 8,
  parameter  int NREG = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [3:0]    issue_op,
  input  logic [RW-1:0] issue_rd,
  input  logic [RW-1:0] issue_rs1,
  input  logic [RW-1:0] issue_rs2,
  input  logic [DW-1:0] issue_imm,
  input  logic          issue_use_imm,
  input  logic          flush,
  output logic          dmem_re,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  output logic          br_valid,
  output logic          br_taken,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data
);

  localparam int SW = $clog2(DW);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_LOAD  = 4'd10;
  localparam logic [3:0] OP_STORE = 4'd11;
  localparam logic [3:0] OP_BEQ   = 4'd12;
  localparam logic [3:0] OP_BNE   = 4'd13;

  // register file
  logic [DW-1:0] regs [NREG];

  // EX stage
  logic          ex_valid;
  logic [3:0]    ex_op;
  logic [RW-1:0] ex_rd;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] ex_imm;
  logic          ex_use_imm;
  logic          ex_we;
`ifdef PIPE_EXEC_FWD_EN
  logic [RW-1:0] ex_rs1;
  logic [RW-1:0] ex_rs2;
`endif

  // MEM stage
  logic          mem_valid;
  logic          mem_we;
  logic [RW-1:0] mem_rd;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] mem_wdata;
  logic          mem_load;
  logic          mem_store;

  // WB stage
  logic          wbk_valid;
  logic          wbk_we;
  logic [RW-1:0] wbk_rd;
  logic [DW-1:0] wbk_result;
  logic          wbk_load;

  // WB commit; register 0 writes are dropped here so they never reach regs
  logic          wb_commit;
  logic [DW-1:0] wb_value;
  assign wb_value  = wbk_load ? dmem_rdata : wbk_result;
  assign wb_commit = wbk_valid && wbk_we && (wbk_rd != '0);

  // ID decode of the presented op
  logic id_writes;
  logic id_reads_rs2;
  assign id_writes    = (issue_op <= OP_LOAD);
  assign id_reads_rs2 = !issue_use_imm || (issue_op == OP_STORE) ||
                        (issue_op == OP_BEQ) || (issue_op == OP_BNE);

  // write-first register read at ID
  logic [DW-1:0] id_a;
  logic [DW-1:0] id_b;
  assign id_a = (issue_rs1 == '0) ? '0 :
                (wb_commit && wbk_rd == issue_rs1) ? wb_value : regs[issue_rs1];
  assign id_b = (issue_rs2 == '0) ? '0 :
                (wb_commit && wbk_rd == issue_rs2) ? wb_value : regs[issue_rs2];

  // issue hazard detection
  logic hazard;
  logic src_match_ex;
  assign src_match_ex = (ex_rd != '0) &&
                        ((ex_rd == issue_rs1) || (id_reads_rs2 && ex_rd == issue_rs2));
`ifdef PIPE_EXEC_FWD_EN
  // only a LOAD in EX cannot be bypassed in time
  assign hazard = ex_valid && (ex_op == OP_LOAD) && src_match_ex;
`else
  logic src_match_mem;
  assign src_match_mem = (mem_rd != '0) &&
                         ((mem_rd == issue_rs1) || (id_reads_rs2 && mem_rd == issue_rs2));
  // wait until the producer has reached WB
  assign hazard = (ex_valid && ex_we && src_match_ex) ||
                  (mem_valid && mem_we && src_match_mem);
`endif

  logic accept;
  assign issue_ready = !reset && !flush && !hazard;
  assign accept      = issue_valid && issue_ready;

  // EX operands
  logic [DW-1:0] op_a;
  logic [DW-1:0] rs_b;
  logic [DW-1:0] alu_b;
  logic [SW-1:0] shamt;
`ifdef PIPE_EXEC_FWD_EN
  logic mem_fwd_ok;
  assign mem_fwd_ok = mem_valid && mem_we && (mem_rd != '0);

  // bypass selection: youngest producer (MEM) wins over WB and the register file
  always_comb begin
    op_a = ex_a;
    rs_b = ex_b;
    if (mem_fwd_ok && mem_rd == ex_rs1)      op_a = mem_result;
    else if (wb_commit && wbk_rd == ex_rs1)  op_a = wb_value;
    if (mem_fwd_ok && mem_rd == ex_rs2)      rs_b = mem_result;
    else if (wb_commit && wbk_rd == ex_rs2)  rs_b = wb_value;
  end
`else
  assign op_a = ex_a;
  assign rs_b = ex_b;
`endif
  assign alu_b = ex_use_imm ? ex_imm : rs_b;
  assign shamt = alu_b[SW-1:0];

  // EX datapath: ALU result or load/store address
  logic [DW-1:0] alu_y;
  always_comb begin
    alu_y = '0;
    case (ex_op)
      OP_ADD:            alu_y = op_a + alu_b;
      OP_SUB:            alu_y = op_a - alu_b;
      OP_AND:            alu_y = op_a & alu_b;
      OP_OR:             alu_y = op_a | alu_b;
      OP_XOR:            alu_y = op_a ^ alu_b;
      OP_SLL:            alu_y = op_a << shamt;
      OP_SRL:            alu_y = op_a >> shamt;
      OP_SRA:            alu_y = $signed(op_a) >>> shamt;
      OP_SLT:            alu_y = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
      OP_SLTU:           alu_y = {{(DW-1){1'b0}}, (op_a < alu_b)};
      OP_LOAD, OP_STORE: alu_y = op_a + ex_imm;
      default:           alu_y = '0;
    endcase
  end

  // branch resolution in EX; a flushed branch reports nothing
  logic ex_branch;
  assign ex_branch = (ex_op == OP_BEQ) || (ex_op == OP_BNE);
  assign br_valid  = ex_valid && !flush && ex_branch;
  assign br_taken  = br_valid && ((ex_op == OP_BEQ) ? (op_a == rs_b) : (op_a != rs_b));

  // ID -> EX: capture the accepted op, otherwise insert a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_op      <= '0;
      ex_rd      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_use_imm <= 1'b0;
      ex_we      <= 1'b0;
`ifdef PIPE_EXEC_FWD_EN
      ex_rs1     <= '0;
      ex_rs2     <= '0;
`endif
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_op      <= issue_op;
        ex_rd      <= issue_rd;
        ex_a       <= id_a;
        ex_b       <= id_b;
        ex_imm     <= issue_imm;
        ex_use_imm <= issue_use_imm;
        ex_we      <= id_writes;
`ifdef PIPE_EXEC_FWD_EN
        ex_rs1     <= issue_rs1;
        ex_rs2     <= issue_rs2;
`endif
      end
    end
  end

  // EX -> MEM: a flush squashes the op leaving EX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_rd     <= '0;
      mem_result <= '0;
      mem_wdata  <= '0;
      mem_load   <= 1'b0;
      mem_store  <= 1'b0;
    end else begin
      mem_valid  <= ex_valid && !flush;
      mem_we     <= ex_we;
      mem_rd     <= ex_rd;
      mem_result <= alu_y;
      mem_wdata  <= rs_b;
      mem_load   <= (ex_op == OP_LOAD);
      mem_store  <= (ex_op == OP_STORE);
    end
  end

  // MEM -> WB: ops past EX always complete
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbk_valid  <= 1'b0;
      wbk_we     <= 1'b0;
      wbk_rd     <= '0;
      wbk_result <= '0;
      wbk_load   <= 1'b0;
    end else begin
      wbk_valid  <= mem_valid;
      wbk_we     <= mem_we;
      wbk_rd     <= mem_rd;
      wbk_result <= mem_result;
      wbk_load   <= mem_load;
    end
  end

  // one register per index, each taking the WB write addressed to it
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      // register gi: load on a committed WB write to index gi
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   regs[gi] <= '0;
        else if (wb_commit && wbk_rd == RW'(gi))     regs[gi] <= wb_value;
      end
    end
  endgenerate

  // memory and writeback outputs are held at zero when idle
  assign dmem_re    = mem_valid && mem_load;
  assign dmem_we    = mem_valid && mem_store;
  assign dmem_addr  = (dmem_re || dmem_we) ? mem_result : '0;
  assign dmem_wdata = dmem_we ? mem_wdata : '0;
  assign wb_valid   = wb_commit;
  assign wb_rd      = wb_commit ? wbk_rd : '0;
  assign wb_data    = wb_commit ? wb_value : '0;

endmodule

// File: tb/tb_pipe_exec_core.sv
// Directed testbench for pipe_exec_core; expectations adapt to PIPE_EXEC_FWD_EN.
module tb_pipe_exec_core;
  localparam int DW   = 8;
  localparam int NREG = 8;
  localparam int RW   = 3;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_LOAD = 4'd10, OP_STORE = 4'd11;
  localparam logic [3:0] OP_BEQ = 4'd12, OP_BNE = 4'd13;

`ifdef PIPE_EXEC_FWD_EN
  localparam int EXP_DEP_STALL = 0;
  localparam int EXP_DEP_GAP   = 1;
  localparam int EXP_LU_STALL  = 1;
`else
  localparam int EXP_DEP_STALL = 2;
  localparam int EXP_DEP_GAP   = 3;
  localparam int EXP_LU_STALL  = 2;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [3:0]    issue_op = '0;
  logic [RW-1:0] issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
  logic [DW-1:0] issue_imm = '0;
  logic          issue_use_imm = 1'b0;
  logic          flush = 1'b0;
  logic          dmem_re, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          br_valid, br_taken, wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  pipe_exec_core #(.DW(DW), .NREG(NREG)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_imm(issue_imm), .issue_use_imm(issue_use_imm), .flush(flush),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .br_valid(br_valid), .br_taken(br_taken),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DW-1:0] load_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // data memory stand-in: every read returns load_data one cycle later
  always @(posedge clk) dmem_rdata <= dmem_re ? load_data : '0;

  // observers: writeback log and memory strobe history
  logic [RW-1:0] log_rd[$];
  logic [DW-1:0] log_data[$];
  int            log_cyc[$];
  int            re_count = 0, we_count = 0;
  logic [DW-1:0] re_addr = '0, we_addr = '0, we_data = '0;

  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      log_rd.push_back(wb_rd);
      log_data.push_back(wb_data);
      log_cyc.push_back(cyc);
      $display("wb  cyc=%0d r%0d=0x%02h", cyc, wb_rd, wb_data);
    end
    if (dmem_re === 1'b1) begin
      re_count <= re_count + 1;
      re_addr  <= dmem_addr;
    end
    if (dmem_we === 1'b1) begin
      we_count <= we_count + 1;
      we_addr  <= dmem_addr;
      we_data  <= dmem_wdata;
    end
  end

  task automatic clear_log();
    log_rd.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // present one op from a negedge and hold it until accepted; returns at the
  // negedge after acceptance (op then sits in EX)
  task automatic do_issue(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                          input logic [DW-1:0] imm, input logic use_imm, output int stalls);
    bit done;
    done          = 1'b0;
    stalls        = 0;
    issue_valid   = 1'b1;
    issue_op      = op;
    issue_rd      = RW'(rd);
    issue_rs1     = RW'(rs1);
    issue_rs2     = RW'(rs2);
    issue_imm     = imm;
    issue_use_imm = use_imm;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (issue_ready === 1'b1) done = 1'b1;
      else stalls++;
      @(negedge clk);
    end
    $display("iss op=%0d rd=%0d rs1=%0d rs2=%0d imm=0x%02h stalls=%0d", op, rd, rs1, rs2, imm, stalls);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout op=%0d issue_ready=0 required=1", op);
    end
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({issue_ready, dmem_re, dmem_we, dmem_addr, dmem_wdata, br_valid, br_taken,
         wb_valid, wb_rd, wb_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=0", {issue_ready, dmem_re, dmem_we,
               dmem_addr, dmem_wdata, br_valid, br_taken, wb_valid, wb_rd, wb_data});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready actual=%b required=1", issue_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    logic [RW-1:0] exp_rd [2] = '{3'd1, 3'd2};
    logic [DW-1:0] exp_d  [2] = '{8'h05, 8'h08};
    clear_log();
    do_issue(OP_ADD, 1, 0, 0, 8'h05, 1'b1, s1);
    do_issue(OP_ADD, 2, 1, 0, 8'h03, 1'b1, s2);
    idle(8);
    checks++;
    if (s2 !== EXP_DEP_STALL) begin
      failures++;
      $display("FAIL b2b_stall actual=%0d required=%0d", s2, EXP_DEP_STALL);
    end
    checks++;
    if (log_rd.size() != 2) begin
      failures++;
      $display("FAIL b2b_wb_count actual=%0d required=2", log_rd.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (log_rd[i] !== exp_rd[i] || log_data[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL b2b_wb%0d actual=r%0d=0x%02h required=r%0d=0x%02h",
                   i, log_rd[i], log_data[i], exp_rd[i], exp_d[i]);
        end
      end
      checks++;
      if (log_cyc[1] - log_cyc[0] != EXP_DEP_GAP) begin
        failures++;
        $display("FAIL b2b_wb_gap actual=%0d required=%0d", log_cyc[1] - log_cyc[0], EXP_DEP_GAP);
      end
    end
  endtask

  task automatic test_load_use();
    int s, s_use, re0;
    logic [RW-1:0] exp_rd [3] = '{3'd1, 3'd3, 3'd4};
    logic [DW-1:0] exp_d  [3] = '{8'h7F, 8'h22, 8'h44};
    clear_log();
    re0       = re_count;
    load_data = 8'h22;
    do_issue(OP_ADD, 1, 0, 0, 8'h7F, 1'b1, s);
    do_issue(OP_LOAD, 3, 1, 0, 8'h01, 1'b1, s);
    do_issue(OP_ADD, 4, 3, 3, 8'h00, 1'b0, s_use);
    idle(8);
    checks++;
    if (re_count - re0 != 1 || re_addr !== 8'h80) begin
      failures++;
      $display("FAIL load_addr actual=%0d reads @0x%02h required=1 read @0x80", re_count - re0, re_addr);
    end
    checks++;
    if (s_use !== EXP_LU_STALL) begin
      failures++;
      $display("FAIL load_use_stall actual=%0d required=%0d", s_use, EXP_LU_STALL);
    end
    checks++;
    if (log_rd.size() != 3) begin
      failures++;
      $display("FAIL load_wb_count actual=%0d required=3", log_rd.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (log_rd[i] !== exp_rd[i] || log_data[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL load_wb%0d actual=r%0d=0x%02h required=r%0d=0x%02h",
                   i, log_rd[i], log_data[i], exp_rd[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_alu();
    int s;
    logic [3:0]    t_op  [13] = '{OP_SRA, OP_SLT, OP_SLTU, OP_ADD, OP_SUB, OP_AND, OP_OR,
                                  OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SUB, OP_SLT};
    int            t_rd  [13] = '{5, 4, 3, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    int            t_rs1 [13] = '{7, 6, 6, 6, 7, 6, 7, 6, 6, 7, 7, 6, 7};
    int            t_rs2 [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 6};
    logic [DW-1:0] t_imm [13] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h81, 8'h3C, 8'h0F,
                                  8'h0F, 8'h09, 8'h07, 8'h0B, 8'h00, 8'h00};
    logic          t_ui  [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [DW-1:0] t_exp [13] = '{8'hC0, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h3C, 8'h8F,
                                  8'hF0, 8'hFE, 8'h01, 8'hF0, 8'h7F, 8'h01};
    clear_log();
    do_issue(OP_ADD, 7, 0, 0, 8'h80, 1'b1, s);
    do_issue(OP_ADD, 6, 0, 0, 8'hFF, 1'b1, s);
    for (int i = 0; i < 13; i++)
      do_issue(t_op[i], t_rd[i], t_rs1[i], t_rs2[i], t_imm[i], t_ui[i], s);
    idle(8);
    checks++;
    if (log_rd.size() != 15) begin
      failures++;
      $display("FAIL alu_wb_count actual=%0d required=15", log_rd.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        checks++;
        if (log_rd[i+2] !== RW'(t_rd[i]) || log_data[i+2] !== t_exp[i]) begin
          failures++;
          $display("FAIL alu_op%0d_case%0d actual=r%0d=0x%02h required=r%0d=0x%02h",
                   t_op[i], i, log_rd[i+2], log_data[i+2], t_rd[i], t_exp[i]);
        end
      end
    end
  endtask

  task automatic test_branch_flush();
    int s, bad;
    clear_log();
    do_issue(OP_ADD, 1, 0, 0, 8'h05, 1'b1, s);
    do_issue(OP_ADD, 2, 0, 0, 8'h08, 1'b1, s);
    do_issue(OP_BNE, 0, 1, 2, 8'h00, 1'b0, s);
    checks++;
    if (br_valid !== 1'b1 || br_taken !== 1'b1) begin
      failures++;
      $display("FAIL bne_taken actual=valid%b/taken%b required=valid1/taken1", br_valid, br_taken);
    end
    do_issue(OP_ADD, 3, 0, 0, 8'h33, 1'b1, s);
    // ADD r3 is now in EX: flush it while presenting another op
    flush         = 1'b1;
    issue_valid   = 1'b1;
    issue_op      = OP_ADD;
    issue_rd      = 3'd4;
    issue_rs1     = 3'd0;
    issue_imm     = 8'h44;
    issue_use_imm = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready actual=%b required=0", issue_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    idle(6);
    bad = 0;
    foreach (log_rd[i]) if (log_rd[i] == 3'd3 || log_rd[i] == 3'd4) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL flush_wb actual=%0d flushed writes required=0", bad);
    end
    do_issue(OP_BEQ, 0, 1, 2, 8'h00, 1'b0, s);
    checks++;
    if (br_valid !== 1'b1 || br_taken !== 1'b0) begin
      failures++;
      $display("FAIL beq_not_taken actual=valid%b/taken%b required=valid1/taken0", br_valid, br_taken);
    end
    idle(4);
  endtask

  task automatic test_r0();
    int s;
    clear_log();
    do_issue(OP_ADD, 0, 0, 0, 8'h09, 1'b1, s);
    do_issue(OP_ADD, 6, 0, 0, 8'h01, 1'b1, s);
    idle(8);
    checks++;
    if (s !== 0) begin
      failures++;
      $display("FAIL r0_no_stall actual=%0d required=0", s);
    end
    checks++;
    if (log_rd.size() != 1) begin
      failures++;
      $display("FAIL r0_wb_count actual=%0d required=1", log_rd.size());
    end else begin
      checks++;
      if (log_rd[0] !== 3'd6 || log_data[0] !== 8'h01) begin
        failures++;
        $display("FAIL r0_wb actual=r%0d=0x%02h required=r6=0x01", log_rd[0], log_data[0]);
      end
    end
  endtask

  task automatic test_reset_store();
    int s, we0;
    we0 = we_count;
    // r1=5, r2=8 from the branch scenario
    do_issue(OP_STORE, 0, 1, 2, 8'h10, 1'b1, s);
    idle(6);
    checks++;
    if (we_count - we0 != 1 || we_addr !== 8'h15 || we_data !== 8'h08) begin
      failures++;
      $display("FAIL store actual=%0d writes @0x%02h=0x%02h required=1 write @0x15=0x08",
               we_count - we0, we_addr, we_data);
    end
    we0 = we_count;
    do_issue(OP_STORE, 0, 2, 1, 8'h20, 1'b1, s);
    reset = 1'b1;
    #1;
    checks++;
    if ({issue_ready, dmem_re, dmem_we, dmem_addr, dmem_wdata, br_valid, br_taken,
         wb_valid, wb_rd, wb_data} !== '0) begin
      failures++;
      $display("FAIL reset_inflight_outputs actual=%h required=0", {issue_ready, dmem_re,
               dmem_we, dmem_addr, dmem_wdata, br_valid, br_taken, wb_valid, wb_rd, wb_data});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_inflight_ready actual=%b required=1", issue_ready);
    end
    @(negedge clk);
    idle(4);
    checks++;
    if (we_count != we0) begin
      failures++;
      $display("FAIL reset_inflight_store actual=%0d writes required=0", we_count - we0);
    end
    clear_log();
    do_issue(OP_ADD, 3, 1, 0, 8'h00, 1'b1, s);
    idle(6);
    checks++;
    if (log_rd.size() != 1 || log_data[0] !== 8'h00) begin
      failures++;
      $display("FAIL reset_regs_cleared actual=%0d writes r3=0x%02h required=1 write r3=0x00",
               log_rd.size(), (log_data.size() > 0) ? log_data[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_alu();
    test_branch_flush();
    test_r0();
    test_reset_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
